// File: rtl/nf10_axis_rr_input_arbiter_if.sv
// -----------------------------------------------------------------------------
// nf10_axis_rr_input_arbiter_if
//
// Bundles the ingress (s_axis_*) and egress (m_axis_*) AXI4-Stream signals of
// the round-robin input arbiter. Ingress vectors are flattened: port i uses
// slice [i*W +: W] of each s_axis_* vector.
//
// Modports:
//   slave  - the arbiter's view: consumes s_axis_* and m_axis_tready,
//            drives s_axis_tready and m_axis_*.
//   master - the surrounding system's view (sources plus converter),
//            the exact mirror of slave.
// -----------------------------------------------------------------------------
interface nf10_axis_rr_input_arbiter_if #(
   parameter int C_NUM_PORTS        = 4,
   parameter int C_AXIS_DATA_WIDTH  = 64,
   parameter int C_AXIS_TUSER_WIDTH = 128
);

   localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

   // Ingress side, one slice per port
   logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata;
   logic [C_NUM_PORTS*STRB_W-1:0]             s_axis_tstrb;
   logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser;
   logic [C_NUM_PORTS-1:0]                    s_axis_tvalid;
   logic [C_NUM_PORTS-1:0]                    s_axis_tready;
   logic [C_NUM_PORTS-1:0]                    s_axis_tlast;

   // Egress side, towards the width converter
   logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata;
   logic [STRB_W-1:0]                         m_axis_tstrb;
   logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser;
   logic                                      m_axis_tvalid;
   logic                                      m_axis_tready;
   logic                                      m_axis_tlast;

   modport slave (
      input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
      output s_axis_tready,
      output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
      input  m_axis_tready
   );

   modport master (
      output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready,
      input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
      output m_axis_tready
   );

endinterface

// File: rtl/nf10_axis_rr_input_arbiter.sv
// -----------------------------------------------------------------------------
// nf10_axis_rr_input_arbiter
//
// Packet-granular round-robin arbiter: shares one AXI4-Stream datapath among
// C_NUM_PORTS ingress streams, handing the output to one port for a whole
// packet (up to and including its tlast beat) so packets never interleave.
// While a port holds the grant, data/strb/tuser/tlast/tvalid pass through
// combinationally and m_axis_tready is steered back to that port only.
// One arbitration cycle (outputs idle) follows every packet.
//
// Ports:
//   axi_aclk    - clock, all state changes on rising edge
//   axi_resetn  - asynchronous active-low reset
//   axis        - ingress/egress stream bundle (slave modport)
//   grant_port  - index of the port holding, or last holding, the grant
// -----------------------------------------------------------------------------
module nf10_axis_rr_input_arbiter #(
   parameter int  C_NUM_PORTS        = 4,
   parameter int  C_AXIS_DATA_WIDTH  = 64,
   parameter int  C_AXIS_TUSER_WIDTH = 128,
   localparam int PTR_W              = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1
) (
   input  logic                         axi_aclk,
   input  logic                         axi_resetn,
   nf10_axis_rr_input_arbiter_if.slave  axis,
   output logic [PTR_W-1:0]             grant_port
);

   localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

   // Port count and highest index expressed in pointer widths, so the
   // wrap arithmetic below never mixes widths.
   localparam logic [PTR_W:0]   NUM_PORTS_W = (PTR_W + 1)'(C_NUM_PORTS);
   localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(C_NUM_PORTS - 1);

   typedef enum logic {
      ST_ARB = 1'b0,   // choosing the next port, outputs idle
      ST_PKT = 1'b1    // granted port streams one packet
   } state_e;

   state_e           state_q,  state_d;
   logic [PTR_W-1:0] grant_q,  grant_d;
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;   // highest-priority port next round

   // Per-port views of the flattened ingress vectors
   logic [C_AXIS_DATA_WIDTH-1:0]  port_data [C_NUM_PORTS];
   logic [STRB_W-1:0]             port_strb [C_NUM_PORTS];
   logic [C_AXIS_TUSER_WIDTH-1:0] port_user [C_NUM_PORTS];

   for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_slice
      assign port_data[gi] = axis.s_axis_tdata[gi*C_AXIS_DATA_WIDTH  +: C_AXIS_DATA_WIDTH];
      assign port_strb[gi] = axis.s_axis_tstrb[gi*STRB_W             +: STRB_W];
      assign port_user[gi] = axis.s_axis_tuser[gi*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
   end

   // --------------------------------------------------------------------------
   // Round-robin search: scan rr_ptr, rr_ptr+1, ... modulo C_NUM_PORTS and
   // take the first valid port.
   // --------------------------------------------------------------------------
   logic             arb_found;
   logic [PTR_W-1:0] arb_winner;
   logic [PTR_W:0]   scan_sum;
   logic [PTR_W-1:0] scan_idx;

   // NOTE: every signal assigned in an always_comb gets a default at the top,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      arb_found  = 1'b0;
      arb_winner = rr_ptr_q;
      scan_sum   = '0;
      scan_idx   = '0;
      for (int k = 0; k < C_NUM_PORTS; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
         if (scan_sum >= NUM_PORTS_W) begin
            scan_sum = scan_sum - NUM_PORTS_W;
         end
         scan_idx = scan_sum[PTR_W-1:0];
         if (!arb_found && axis.s_axis_tvalid[scan_idx]) begin
            arb_found  = 1'b1;
            arb_winner = scan_idx;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Datapath: zero-latency pass-through of the granted port. Data fields
   // follow grant even while idle (port 0 out of reset); only tvalid and
   // tlast are qualified by the state.
   // --------------------------------------------------------------------------
   logic in_pkt;
   logic beat_xfer;

   assign in_pkt    = (state_q == ST_PKT);
   assign beat_xfer = in_pkt & axis.s_axis_tvalid[grant_q] & axis.m_axis_tready;

   assign axis.m_axis_tdata  = port_data[grant_q];
   assign axis.m_axis_tstrb  = port_strb[grant_q];
   assign axis.m_axis_tuser  = port_user[grant_q];
   assign axis.m_axis_tvalid = in_pkt & axis.s_axis_tvalid[grant_q];
   assign axis.m_axis_tlast  = in_pkt & axis.s_axis_tlast[grant_q];

   always_comb begin
      axis.s_axis_tready = '0;
      if (in_pkt) begin
         axis.s_axis_tready[grant_q] = axis.m_axis_tready;
      end
   end

   assign grant_port = grant_q;

   // --------------------------------------------------------------------------
   // Next-state logic. The grant is only released by a tlast transfer; a
   // granted port dropping tvalid mid-packet simply stalls the output.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         ST_ARB: begin
            if (arb_found) begin
               grant_d = arb_winner;
               state_d = ST_PKT;
            end
         end
         ST_PKT: begin
            if (beat_xfer && axis.s_axis_tlast[grant_q]) begin
               state_d = ST_ARB;
               // Explicit wrap keeps rr_ptr in range for non-power-of-two counts
               rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + PTR_W'(1);
            end
         end
         default: state_d = ST_ARB;
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values, independent of statement order.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q  <= ST_ARB;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_nf10_axis_rr_input_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nf10_axis_rr_input_arbiter
//
// Directed bench for the round-robin input arbiter. A 4-port instance is fed
// by per-port packet sources; every beat handed to a source in the expected
// output order is also pushed to a scoreboard queue, and a monitor pops and
// compares each beat the arbiter emits. A 3-port instance exercises pointer
// wrap for a non-power-of-two port count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nf10_axis_rr_input_arbiter;

   localparam int NP = 4;
   localparam int DW = 64;
   localparam int UW = 128;
   localparam int SW = DW / 8;

   typedef struct {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic [UW-1:0] user;
      logic          last;
      int            port;
      int            gap;    // idle cycles on the source before this beat
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nf10_axis_rr_input_arbiter_if #(.C_NUM_PORTS(NP), .C_AXIS_DATA_WIDTH(DW),
                                   .C_AXIS_TUSER_WIDTH(UW)) bus4 ();
   nf10_axis_rr_input_arbiter_if #(.C_NUM_PORTS(3),  .C_AXIS_DATA_WIDTH(DW),
                                   .C_AXIS_TUSER_WIDTH(UW)) bus3 ();
   logic [1:0] grant4;
   logic [1:0] grant3;

   nf10_axis_rr_input_arbiter #(.C_NUM_PORTS(NP), .C_AXIS_DATA_WIDTH(DW),
                                .C_AXIS_TUSER_WIDTH(UW)) dut4 (
      .axi_aclk   (clk),
      .axi_resetn (rst_n),
      .axis       (bus4),
      .grant_port (grant4)
   );

   nf10_axis_rr_input_arbiter #(.C_NUM_PORTS(3), .C_AXIS_DATA_WIDTH(DW),
                                .C_AXIS_TUSER_WIDTH(UW)) dut3 (
      .axi_aclk   (clk),
      .axi_resetn (rst_n),
      .axis       (bus3),
      .grant_port (grant3)
   );

   int      n_total = 0;
   int      n_pass  = 0;
   int      n_fail  = 0;
   beat_t   src_q [NP][$];
   beat_t   exp_q [$];
   logic [NP-1:0] fire;
   int      gap_left [NP];
   int      cyc  = 0;
   int      vcyc = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------- sources
   task automatic present();
      logic [NP*DW-1:0] d;
      logic [NP*SW-1:0] s;
      logic [NP*UW-1:0] u;
      logic [NP-1:0]    v;
      logic [NP-1:0]    l;
      d = '0; s = '0; u = '0; v = '0; l = '0;
      for (int i = 0; i < NP; i++) begin
         if (src_q[i].size() > 0 && gap_left[i] == 0) begin
            d[i*DW +: DW] = src_q[i][0].data;
            s[i*SW +: SW] = src_q[i][0].strb;
            u[i*UW +: UW] = src_q[i][0].user;
            l[i]          = src_q[i][0].last;
            v[i]          = 1'b1;
         end
      end
      bus4.s_axis_tdata  = d;
      bus4.s_axis_tstrb  = s;
      bus4.s_axis_tuser  = u;
      bus4.s_axis_tvalid = v;
      bus4.s_axis_tlast  = l;
   endtask

   initial begin : src_driver
      for (int i = 0; i < NP; i++) gap_left[i] = 0;
      fire = '0;
      forever begin
         present();
         @(negedge clk);
         fire = bus4.s_axis_tvalid & bus4.s_axis_tready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NP; i++) begin
            if (fire[i] && src_q[i].size() > 0) begin
               void'(src_q[i].pop_front());
               gap_left[i] = (src_q[i].size() > 0) ? src_q[i][0].gap : 0;
            end else if (gap_left[i] > 0) begin
               gap_left[i]--;
            end
         end
      end
   end

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      beat_t b;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (bus4.m_axis_tvalid) vcyc++;
            if (bus4.m_axis_tvalid && bus4.m_axis_tready) begin
               check("beat_expected", 128'(exp_q.size() != 0), 128'd1);
               if (exp_q.size() != 0) begin
                  b = exp_q.pop_front();
                  check("out_tdata", bus4.m_axis_tdata, b.data);
                  check("out_tstrb", bus4.m_axis_tstrb, b.strb);
                  check("out_tuser", bus4.m_axis_tuser, b.user);
                  check("out_tlast", bus4.m_axis_tlast, b.last);
                  check("out_grant", grant4, b.port);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- helpers
   task automatic load(input int port, input int nbeats, input bit to_exp,
                       input int gap_at, input int gap_len, input bit fixed);
      for (int b = 0; b < nbeats; b++) begin
         beat_t      x;
         logic [7:0] bv;
         bv     = 8'(8'h11 * (b + 1));
         x.data = fixed ? {8{bv}} : {$urandom, $urandom};
         x.strb = fixed ? 8'hFF : 8'($urandom);
         x.user = {$urandom, $urandom, $urandom, $urandom};
         x.last = (b == nbeats - 1);
         x.port = port;
         x.gap  = (b == gap_at) ? gap_len : 0;
         src_q[port].push_back(x);
         if (to_exp) exp_q.push_back(x);
      end
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic flush();
      exp_q.delete();
      for (int i = 0; i < NP; i++) src_q[i].delete();
   endtask

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      check({tag, "_drained"}, exp_q.size(), 0);
      exp_q.delete();
      #2;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      flush();
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------------------------------------------------------- stimulus
   initial begin : stim
      int          c0, v0, got;
      int          seq [4];
      logic [63:0] pdata [3];
      logic        pat [7];

      seq      = '{0, 2, 0, 2};
      pdata    = '{64'hAAAA_0000_0000_AAAA, 64'hBBBB_1111_1111_BBBB, 64'hCCCC_2222_2222_CCCC};
      pat      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      bus4.m_axis_tready = 1'b1;
      bus3.s_axis_tdata  = '0;
      bus3.s_axis_tstrb  = '0;
      bus3.s_axis_tuser  = '0;
      bus3.s_axis_tvalid = '0;
      bus3.s_axis_tlast  = '0;
      bus3.m_axis_tready = 1'b1;
      rst_n = 1'b0;

      // Reset held with every port offering a beat
      for (int p = 0; p < NP; p++) load(p, 1, 1'b0, -1, 0, 1'b0);
      settle();
      @(negedge clk);
      check("rst_m_tvalid", bus4.m_axis_tvalid, 1'b0);
      check("rst_s_tready", bus4.s_axis_tready, 4'b0000);
      check("rst_grant",    grant4, 2'd0);
      check("rst_m_tlast",  bus4.m_axis_tlast, 1'b0);
      flush();
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset asserted mid-packet on port 2
      load(2, 4, 1'b1, -1, 0, 1'b0);
      settle();
      @(negedge clk);
      check("mid_arb_tvalid", bus4.m_axis_tvalid, 1'b0);
      @(negedge clk);
      check("mid_pkt_tvalid", bus4.m_axis_tvalid, 1'b1);
      check("mid_pkt_grant",  grant4, 2'd2);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_m_tvalid", bus4.m_axis_tvalid, 1'b0);
      check("mid_rst_s_tready", bus4.s_axis_tready, 4'b0000);
      check("mid_rst_grant",    grant4, 2'd0);
      check("mid_rst_m_tlast",  bus4.m_axis_tlast, 1'b0);
      flush();
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Single port: 3-beat packet on port 1, one-cycle arbitration latency
      load(1, 3, 1'b1, -1, 0, 1'b1);
      settle();
      @(negedge clk);
      check("sp_latency_tvalid", bus4.m_axis_tvalid, 1'b0);
      @(negedge clk);
      check("sp_first_tvalid", bus4.m_axis_tvalid, 1'b1);
      check("sp_grant",        grant4, 2'd1);
      check("sp_s_tready",     bus4.s_axis_tready, 4'b0010);
      drain("sp", 20);

      // Backpressure on port 3: tready pattern 1,0,0,1 then 1,1
      load(3, 4, 1'b1, -1, 0, 1'b0);
      settle();
      for (int k = 0; k < 7; k++) begin
         bus4.m_axis_tready = pat[k];
         @(negedge clk);
         check("bp_s_tready", bus4.s_axis_tready, (k == 0) ? 4'b0000 : {pat[k], 3'b000});
         if (k > 0) check("bp_m_tvalid", bus4.m_axis_tvalid, 1'b1);
         @(posedge clk);
         #2;
      end
      bus4.m_axis_tready = 1'b1;
      drain("bp", 10);

      // No interleave: port 0 stalls 5 cycles mid-packet while port 2 waits
      load(0, 3, 1'b1, 1, 5, 1'b0);
      load(2, 1, 1'b1, -1, 0, 1'b0);
      settle();
      @(negedge clk);
      check("ni_arb_tvalid", bus4.m_axis_tvalid, 1'b0);
      @(negedge clk);
      check("ni_first_tvalid", bus4.m_axis_tvalid, 1'b1);
      check("ni_first_grant",  grant4, 2'd0);
      repeat (5) begin
         @(negedge clk);
         check("ni_gap_tvalid",  bus4.m_axis_tvalid, 1'b0);
         check("ni_gap_grant",   grant4, 2'd0);
         check("ni_gap_ready2",  bus4.s_axis_tready[2], 1'b0);
      end
      @(negedge clk);
      check("ni_resume_tvalid", bus4.m_axis_tvalid, 1'b1);
      check("ni_resume_grant",  grant4, 2'd0);
      drain("ni", 20);

      // Round robin: all ports saturated with 2-beat packets
      do_reset();
      load(0, 2, 1'b1, -1, 0, 1'b0);
      load(1, 2, 1'b1, -1, 0, 1'b0);
      load(2, 2, 1'b1, -1, 0, 1'b0);
      load(3, 2, 1'b1, -1, 0, 1'b0);
      load(0, 2, 1'b1, -1, 0, 1'b0);
      load(1, 2, 1'b1, -1, 0, 1'b0);
      settle();
      c0 = cyc;
      v0 = vcyc;
      drain("rr", 60);
      check("rr_cycles",       cyc - c0, 18);
      check("rr_valid_cycles", vcyc - v0, 12);

      // Three ports, ports 0 and 2 saturated with 1-beat packets
      do_reset();
      bus3.s_axis_tdata  = {pdata[2], pdata[1], pdata[0]};
      bus3.s_axis_tlast  = 3'b111;
      bus3.s_axis_tvalid = 3'b101;
      got = 0;
      for (int n = 0; n < 40 && got < 4; n++) begin
         @(negedge clk);
         if (bus3.m_axis_tvalid) begin
            check("n3_grant", grant3, seq[got]);
            check("n3_data",  bus3.m_axis_tdata, pdata[seq[got]]);
            got++;
         end
      end
      check("n3_grant_count", got, 4);
      bus3.s_axis_tvalid = 3'b000;

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/nf10_axis_rr_input_arbiter.md
# nf10_axis_rr_input_arbiter

Packet-granular round-robin arbiter that shares one 64-bit AXI4-Stream datapath among C_NUM_PORTS 64-bit ingress streams. It sits directly upstream of the 64->256 nf10_axis_converter and feeds it one complete packet at a time, so beats from different ports never interleave. Data, strobe and tuser pass through unmodified and unregistered once a port holds the grant.

## Interface
Parameters:
- C_NUM_PORTS, 4: number of slave streams; legal range 2..8.
- C_AXIS_DATA_WIDTH, 64: tdata width, shared by all ports.
- C_AXIS_TUSER_WIDTH, 128: tuser width, shared by all ports.

Ports (port i occupies slice [i*W +: W] of each flattened vector):
- axi_aclk  in  1  sole clock; all state changes on its rising edge.
- axi_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  C_NUM_PORTS*C_AXIS_DATA_WIDTH  ingress data.
- s_axis_tstrb  in  C_NUM_PORTS*C_AXIS_DATA_WIDTH/8  ingress byte strobes.
- s_axis_tuser  in  C_NUM_PORTS*C_AXIS_TUSER_WIDTH  ingress sideband (len/spt/dpt).
- s_axis_tvalid  in  C_NUM_PORTS  per-port valid.
- s_axis_tready  out  C_NUM_PORTS  per-port ready.
- s_axis_tlast  in  C_NUM_PORTS  per-port end of packet.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  to converter.
- m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  to converter.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  to converter.
- m_axis_tvalid  out  1  to converter.
- m_axis_tready  in  1  from converter.
- m_axis_tlast  out  1  to converter.
- grant_port  out  clog2(C_NUM_PORTS) (min 1)  index of port holding or last holding grant; status only.

## Operation
- State machine, two states: ARB and PKT. Registers: state, grant (index), rr_ptr (index of highest-priority port).
- ARB: s_axis_tready = 0 for all ports; m_axis_tvalid = 0. Search ports in order rr_ptr, rr_ptr+1, ... wrapping modulo C_NUM_PORTS; first port with tvalid=1 wins. On that edge grant <= winner, state <= PKT. No valid -> stay ARB, grant unchanged.
- PKT: m_axis_{tdata,tstrb,tuser,tlast,tvalid} = slice [grant] of s_axis_*; s_axis_tready[grant] = m_axis_tready; all other s_axis_tready = 0.
- Beat transfer = tvalid[grant] & m_axis_tready. Transfer with tlast=1 -> state <= ARB, rr_ptr <= (grant+1) mod C_NUM_PORTS. Transfer without tlast -> stay PKT.
- Granted port deasserting tvalid mid-packet: remain in PKT, m_axis_tvalid follows it low; grant never released before tlast.
- Non-power-of-two C_NUM_PORTS: wrap increment explicitly compares against C_NUM_PORTS-1; rr_ptr never holds an out-of-range value.
- grant_port = grant register.

## Timing
- Reset (axi_resetn low, effective immediately, asynchronous): state=ARB, grant=0, rr_ptr=0; therefore m_axis_tvalid=0, m_axis_tlast=0, all s_axis_tready=0, grant_port=0. m_axis_tdata/tstrb/tuser reflect port 0 slice (don't-care while tvalid=0). Release takes effect on first rising edge with axi_resetn high.
- Reset mid-packet: packet aborted; downstream sees truncated packet without tlast. Accepted behaviour; recovery is a system-level reset of the whole pipeline.
- Arbitration latency: 1 cycle. A port asserting tvalid in cycle N while arbiter is in ARB gets m_axis_tvalid in cycle N+1.
- Per-packet overhead: exactly one ARB bubble after each tlast beat; 1-beat packets from saturated ports yield 50% throughput, N-beat packets N/(N+1).
- Datapath in PKT is purely combinational (zero latency); m_axis_tready -> s_axis_tready is combinational.
- Fairness: with all ports continuously valid, grants rotate 0,1,...,C_NUM_PORTS-1,0; no port waits more than C_NUM_PORTS-1 packets.

## Test plan
- Reset: hold axi_resetn=0 with all tvalid=1 -> m_axis_tvalid=0, s_axis_tready=4'b0000, grant_port=0; assert reset mid-packet on port 2 -> outputs drop to reset values same cycle.
- Single port: port 1 sends 3-beat packet (tdata 0x11..,0x22..,0x33.., tlast on beat 3), m_axis_tready=1 -> m_axis emits the same 3 beats starting one cycle after first tvalid, tuser/tstrb bit-identical, grant_port=1.
- Round robin: all 4 ports continuously offer 2-beat packets -> output packet source order 0,1,2,3,0,1 with one idle cycle between packets (8 beats per 12 cycles... 2 of every 3 cycles valid).
- Backpressure: port 3 in PKT, m_axis_tready toggles 1,0,0,1 -> s_axis_tready[3] mirrors it exactly, other readies stay 0, no beat lost or duplicated.
- No interleave: port 0 mid-packet drops tvalid for 5 cycles while port 2 valid -> grant stays 0, m_axis_tvalid=0 during gap, port 2 served only after port 0 tlast.
- C_NUM_PORTS=3: ports 0 and 2 saturated -> grant sequence 0,2,0,2; rr_ptr wraps 2->0, never reaches 3.
